fetch_predict_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined RISC-V core with static backward-taken/forward-not-taken (BTFN) prediction. It holds the PC and drives the instruction-memory address. It pre-decodes each fetched word to predict `jal` and conditional branches, and registers instruction, PC and prediction into the IF/ID pipeline register. The ID stage opcode decode consumes `InstrD[6:0]`. Mispredict correction arrives from EX as a redirect.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/static_branch_predictor.sv | 37 +++
 rtl/fetch_predict_stage.sv | 86 ++++++++
 tb/tb_fetch_predict_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcodes, the canonical NOP and the IF/ID pipeline bundle.
package riscv_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        valid;
    } if_id_t;

    // A bubble looks like "addi x0,x0,0" at PC 0, so decode sees a harmless write to x0.
    localparam if_id_t IF_ID_BUBBLE = '{
        instr:       NOP_INSTR,
        pc:          32'h0000_0000,
        pc_plus4:    32'h0000_0004,
        pred_taken:  1'b0,
        pred_target: 32'h0000_0004,
        valid:       1'b0
    };

endpackage

// File: rtl/static_branch_predictor.sv
// Backward-taken / forward-not-taken predictor; JAL always taken, JALR never.
module static_branch_predictor
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;

    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc + 32'd4;
        case (instr[6:0])
            OP_JAL: begin
                pred_taken  = 1'b1;
                pred_target = pc + $unsigned(imm_j);
            end
            OP_BRANCH: begin
                // Sign bit of the offset decides direction: backward loops are taken.
                if (imm_b[31]) begin
                    pred_taken  = 1'b1;
                    pred_target = pc + $unsigned(imm_b);
                end
            end
            OP_JALR: pred_taken = 1'b0;
            default: pred_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_predict_stage.sv
// IF stage: PC register, static prediction on the fetched word, and the IF/ID register.
module fetch_predict_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] ImemAddrF,
    input  logic [XLEN-1:0] ImemRdataF,
    output logic [XLEN-1:0] PCF,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            RedirectE,
    input  logic [XLEN-1:0] RedirectPCE,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            PredTakenD,
    output logic [XLEN-1:0] PredTargetD,
    output logic            ValidD
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    if_id_t      ifid_q, ifid_d;

    static_branch_predictor u_pred (
        .instr       (ImemRdataF),
        .pc          (pc_q),
        .pred_taken  (pred_taken_f),
        .pred_target (pred_target_f)
    );

    assign pc_plus4_f = pc_q + 32'd4;

    // Redirect outranks stall so a mispredict is never swallowed by a hazard hold.
    always_comb begin
        pc_d = pc_plus4_f;
        if (RedirectE)         pc_d = RedirectPCE;
        else if (StallF)       pc_d = pc_q;
        else if (pred_taken_f) pc_d = pred_target_f;
    end

    always_comb begin
        ifid_d = '{
            instr:       ImemRdataF,
            pc:          pc_q,
            pc_plus4:    pc_plus4_f,
            pred_taken:  pred_taken_f,
            pred_target: pred_target_f,
            valid:       1'b1
        };
        if (RedirectE || FlushD) ifid_d = IF_ID_BUBBLE;
        else if (StallD)         ifid_d = ifid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ifid_q <= IF_ID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign PCF         = pc_q;
    assign ImemAddrF   = pc_q;
    assign InstrD      = ifid_q.instr;
    assign PCD         = ifid_q.pc;
    assign PCPlus4D    = ifid_q.pc_plus4;
    assign PredTakenD  = ifid_q.pred_taken;
    assign PredTargetD = ifid_q.pred_target;
    assign ValidD      = ifid_q.valid;

    a_stall_combo: assert property (@(posedge clk) disable iff (reset) !(StallF && !StallD))
        else $error("fetch_predict_stage: StallF without StallD");
    a_redirect_align: assert property (@(posedge clk) disable iff (reset) !(RedirectE && (RedirectPCE[1:0] != 2'b00)))
        else $error("fetch_predict_stage: misaligned RedirectPCE");

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench for fetch_predict_stage with a per-cycle expectation scoreboard.
module tb_fetch_predict_stage;

    localparam logic [31:0] ADD = 32'h0020_81b3;  // add x3,x1,x2
    localparam logic [31:0] BEQ = 32'hfe00_0ce3;  // beq x0,x0,-8
    localparam logic [31:0] BNE = 32'h0000_9863;  // bne x1,x0,+16
    localparam logic [31:0] JAL = 32'h1000_00ef;  // jal x1,+0x100
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, RedirectE;
    logic [31:0] RedirectPCE, ImemAddrF, ImemRdataF, PCF;
    logic [31:0] InstrD, PCD, PCPlus4D, PredTargetD;
    logic        PredTakenD, ValidD;
    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        pt;
        logic [31:0] tgt;
        logic        v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign ImemRdataF = mem[ImemAddrF[9:2]];

    fetch_predict_stage #(.RESET_PC(32'h0), .XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .ImemAddrF   (ImemAddrF),
        .ImemRdataF  (ImemRdataF),
        .PCF         (PCF),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .RedirectE   (RedirectE),
        .RedirectPCE (RedirectPCE),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .PredTakenD  (PredTakenD),
        .PredTargetD (PredTargetD),
        .ValidD      (ValidD)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the state expected after the next edge, then advance and compare against the head.
    task automatic step(input string name, input logic [31:0] pcf, input logic [31:0] instr,
                        input logic [31:0] pcd, input logic pt, input logic [31:0] tgt, input logic v);
        exp_t e;
        e = '{name: name, pcf: pcf, instr: instr, pcd: pcd, pt: pt, tgt: tgt, v: v};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: got empty expected entry", name);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".PCF"},         PCF,              e.pcf);
            chk({e.name, ".ImemAddrF"},   ImemAddrF,        e.pcf);
            chk({e.name, ".InstrD"},      InstrD,           e.instr);
            chk({e.name, ".PCD"},         PCD,              e.pcd);
            chk({e.name, ".PCPlus4D"},    PCPlus4D,         e.pcd + 32'd4);
            chk({e.name, ".PredTakenD"},  {31'd0, PredTakenD}, {31'd0, e.pt});
            chk({e.name, ".PredTargetD"}, PredTargetD,      e.tgt);
            chk({e.name, ".ValidD"},      {31'd0, ValidD},  {31'd0, e.v});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ADD;
        mem[8]  = BEQ;
        mem[16] = JAL;
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        RedirectE = 1'b0; RedirectPCE = 32'h0;

        step("rst0", 32'h0, NOP, 32'h0, 1'b0, 32'h4, 1'b0);
        step("rst1", 32'h0, NOP, 32'h0, 1'b0, 32'h4, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            step("line", (i + 1) * 4, ADD, i * 4, 1'b0, i * 4 + 4, 1'b1);

        step("beq_back",  32'h18, BEQ, 32'h20, 1'b1, 32'h18, 1'b1);
        step("beq_tgt",   32'h1c, ADD, 32'h18, 1'b0, 32'h1c, 1'b1);
        mem[8] = BNE;
        step("pre_bne",   32'h20, ADD, 32'h1c, 1'b0, 32'h20, 1'b1);
        step("bne_fwd",   32'h24, BNE, 32'h20, 1'b0, 32'h24, 1'b1);
        for (int p = 32'h24; p < 32'h40; p += 4)
            step("line2", p + 4, ADD, p, 1'b0, p + 4, 1'b1);
        step("jal",       32'h140, JAL, 32'h40, 1'b1, 32'h140, 1'b1);
        step("jal_tgt",   32'h144, ADD, 32'h140, 1'b0, 32'h144, 1'b1);

        RedirectE = 1'b1; RedirectPCE = 32'h80; StallF = 1'b1; StallD = 1'b1;
        step("redir_over_stall", 32'h80, NOP, 32'h0, 1'b0, 32'h4, 1'b0);
        RedirectE = 1'b0; StallF = 1'b0; StallD = 1'b0;
        step("post_redir", 32'h84, ADD, 32'h80, 1'b0, 32'h84, 1'b1);

        StallF = 1'b1; StallD = 1'b1;
        step("stall1", 32'h84, ADD, 32'h80, 1'b0, 32'h84, 1'b1);
        step("stall2", 32'h84, ADD, 32'h80, 1'b0, 32'h84, 1'b1);
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b1;
        step("flush", 32'h88, NOP, 32'h0, 1'b0, 32'h4, 1'b0);
        FlushD = 1'b0;
        step("post_flush", 32'h8c, ADD, 32'h88, 1'b0, 32'h8c, 1'b1);

        reset = 1'b1; RedirectE = 1'b1; RedirectPCE = 32'h80; StallF = 1'b1; StallD = 1'b1;
        step("mid_reset", 32'h0, NOP, 32'h0, 1'b0, 32'h4, 1'b0);
        reset = 1'b0; RedirectE = 1'b0; StallF = 1'b0; StallD = 1'b0;
        step("after_reset", 32'h4, ADD, 32'h0, 1'b0, 32'h4, 1'b1);

        // Backward branch at PC 4 wraps the target below zero.
        mem[1] = BEQ;
        step("wrap_branch", 32'hffff_fffc, BEQ, 32'h4, 1'b1, 32'hffff_fffc, 1'b1);
        step("wrap_plus4",  32'h0, ADD, 32'hffff_fffc, 1'b0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
